nand_latch_seq: RTL and testbench
=================================

// Module: nand_latch_seq
// PURPOSE
// Parametrised command/address latch sequencer for the ONFI NAND controller.
// One start issues a full latch sequence: CMD0, 0..MAX_ADDR address bytes, optional CMD1.
// The sequencer drives CLE, ALE, WE# and DQ with per-phase timing counts, so callers stop chaining single-byte latches.
// Sits between the controller FSM and the NAND pad ring.
// PARAMETERS
// DATA_W    16  DQ bus width (8 or 16); bytes drive DQ[7:0], upper bits 0
// MAX_ADDR   5  max address cycles per sequence (1..8)
// T_WP       3  WE# low cycles per byte (t_WP); 0 treated as 1
// T_WH       2  WE# high cycles between bytes (t_WH); 0 treated as 1
// T_CLH      2  CLE hold cycles after last WE# rise of a command byte
// T_ALH      2  ALE hold cycles after last WE# rise of an address byte
// PORTS
// clk       in   1            system clock, all logic on rising edge
// rst       in   1            asynchronous, active-high reset
// start     in   1            1-cycle request; ignored while busy=1
// cmd0      in   8            first command byte
// addr      in   8*MAX_ADDR   address bytes, byte k at [8k+7:8k], k=0 issued first
// addr_cnt  in   4            number of address bytes, 0..MAX_ADDR
// cmd1_en   in   1            1: issue cmd1 after the address bytes
// cmd1      in   8            second command byte (e.g. 0x30 page read confirm)
// cle       out  1            command latch enable
// ale       out  1            address latch enable
// we_n      out  1            write enable, active low
// dq_out    out  DATA_W       DQ drive value
// dq_oe     out  1            DQ output enable
// busy      out  1            sequence in progress
// done      out  1            1-cycle pulse, sequence complete
// err       out  1            1-cycle pulse, start rejected (addr_cnt > MAX_ADDR)
// BEHAVIOUR
// - Reset (async), and IDLE state: cle=0 ale=0 we_n=1 dq_out=0 dq_oe=0 busy=0 done=0 err=0.
// - Reset takes effect immediately, even mid-byte. State returns to IDLE and counters clear.
// - All outputs are registered. cmd0/addr/addr_cnt/cmd1_en/cmd1 are captured on the accepted start edge.
// - FSM: IDLE -> WP -> WH -> (WP of next byte | HOLD) -> DONE -> IDLE.
//   - WP: T_WP cycles. we_n=0, dq_oe=1, dq_out=current byte. cle=1 for a cmd byte, ale=1 for an addr byte.
//   - WH (more bytes follow): we_n=1; cle/ale/dq/dq_oe held.
//     Length T_WH, extended to max(T_WH,T_CLH) for a cmd byte or max(T_WH,T_ALH) for an addr byte, when the next byte is of a different type.
//   - HOLD (after last byte): we_n=1; cle/ale/dq held for T_CLH (cmd) or T_ALH (addr) cycles.
//   - DONE: 1 cycle. done=1, busy=1, all bus outputs at idle values. Next cycle IDLE, busy=0.
// - Byte order: cmd0, addr[0]..addr[addr_cnt-1], then cmd1 if cmd1_en=1.
// - cle and ale are never high in the same cycle. We_n changes only at phase boundaries.
// - Latency: busy rises the cycle after start. The first WP cycle is that same cycle.
// - addr_cnt=0 with cmd1_en=0: single command latch. addr_cnt=0 with cmd1_en=1: cmd0 then cmd1.
// - start with addr_cnt > MAX_ADDR: err=1 next cycle, no bus activity, busy stays 0.
// - start while busy is ignored with no err. start in the DONE cycle is also ignored.
// - Phase counters are sized for max(T_*) and reload at each phase entry. There is no wrap-around within a phase.
// TESTING
// Reset values: assert rst mid-WP of an addr byte -> same cycle ale=0, we_n=1, dq_oe=0, busy=0; after release, a new start runs normally.
// Single cmd 0xFF, addr_cnt=0, cmd1_en=0, defaults, start @0 -> cyc1-3 cle=1 we_n=0 dq_out=0x00FF; cyc4-5 cle=1 we_n=1; cyc6 done=1; cyc7 busy=0.
// Page read: cmd0=0x00, addr=0x0201_0000_00 (5 bytes), cmd1=0x30 -> 7 bytes x 5 cycles on the bus; ale high for exactly 5 WE# pulses; done at cyc36.
// addr_cnt=6 with MAX_ADDR=5 -> err=1 at cyc1; cle=ale=0 and we_n=1 throughout.
// start re-pulsed at cyc3 of a running sequence -> ignored: same timing as the single-pulse case, single done pulse.
// DATA_W=8, T_WP=1, T_WH=1, T_CLH=4: cmd 0x70 + 1 addr -> 1-cycle WE# lows; cle stays high 4 cycles after the WE# rise before ale rises.

Source files
------------

// File: rtl/nand_latch_seq.sv
// ONFI command/address latch sequencer.
// Issues cmd0, up to MAX_ADDR address bytes and an optional cmd1 with WE# timing.
module nand_latch_seq #(
  parameter int DATA_W   = 16,
  parameter int MAX_ADDR = 5,
  parameter int T_WP     = 3,
  parameter int T_WH     = 2,
  parameter int T_CLH    = 2,
  parameter int T_ALH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            cmd0,
  input  logic [8*MAX_ADDR-1:0] addr,
  input  logic [3:0]            addr_cnt,
  input  logic                  cmd1_en,
  input  logic [7:0]            cmd1,
  output logic                  cle,
  output logic                  ale,
  output logic                  we_n,
  output logic [DATA_W-1:0]     dq_out,
  output logic                  dq_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int TWP  = (T_WP < 1) ? 1 : T_WP;
  localparam int TWH  = (T_WH < 1) ? 1 : T_WH;
  localparam int TWHC = (T_CLH > TWH) ? T_CLH : TWH;
  localparam int TWHA = (T_ALH > TWH) ? T_ALH : TWH;
  localparam int M1   = (TWP > TWHC) ? TWP : TWHC;
  localparam int MAXT = (M1 > TWHA) ? M1 : TWHA;
  localparam int CW   = (MAXT < 2) ? 1 : $clog2(MAXT);

  localparam logic [CW-1:0] LWP  = CW'(TWP - 1);
  localparam logic [CW-1:0] LWH  = CW'(TWH - 1);
  localparam logic [CW-1:0] LWHC = CW'(TWHC - 1);
  localparam logic [CW-1:0] LWHA = CW'(TWHA - 1);
  localparam logic [CW-1:0] LCLH = CW'((T_CLH > 0) ? T_CLH - 1 : 0);
  localparam logic [CW-1:0] LALH = CW'((T_ALH > 0) ? T_ALH - 1 : 0);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [3:0]    MAXA = 4'(MAX_ADDR);
  localparam bit            CLH0 = (T_CLH < 1);
  localparam bit            ALH0 = (T_ALH < 1);

  typedef enum logic [2:0] {
    IDLE, WP, WH, HOLD, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [7:0]            cmd0_q, cmd1_q;
  logic [8*MAX_ADDR-1:0] addr_q;
  logic [3:0]            acnt_q;
  logic                  c1en_q;
  logic                  cap;
  logic [3:0]            last_idx;
  logic                  cur_cmd, nxt_cmd, nb_cmd;
  logic [7:0]            nb_byte;

  logic                  cle_q, cle_d, ale_q, ale_d;
  logic                  wen_q, wen_d, oe_q, oe_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     dq_q, dq_d;

  assign last_idx = acnt_q + {3'b000, c1en_q};
  assign cur_cmd  = (idx_q == 4'd0) || (idx_q > acnt_q);
  assign nxt_cmd  = (idx_q + 4'd1) > acnt_q;
  assign nb_cmd   = (idx_d == 4'd0) || (idx_d > acnt_q);

  // Byte to drive for the phase being entered.
  always_comb begin
    nb_byte = cmd1_q;
    if (state_q == IDLE || idx_d == 4'd0) begin
      nb_byte = (state_q == IDLE) ? cmd0 : cmd0_q;
    end else begin
      for (int k = 0; k < MAX_ADDR; k++) begin
        if (4'(k + 1) == idx_d && idx_d <= acnt_q) nb_byte = addr_q[8*k +: 8];
      end
    end
  end

  // Phase sequencing: state, phase counter and byte index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (addr_cnt > MAXA) begin
            err_d = 1'b1;
          end else begin
            cap     = 1'b1;
            state_d = WP;
            idx_d   = 4'd0;
            cnt_d   = LWP;
          end
        end
      end
      WP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (idx_q == last_idx) begin
          if (cur_cmd ? CLH0 : ALH0) begin
            state_d = DONE;
          end else begin
            state_d = HOLD;
            cnt_d   = cur_cmd ? LCLH : LALH;
          end
        end else begin
          state_d = WH;
          if (cur_cmd != nxt_cmd) cnt_d = cur_cmd ? LWHC : LWHA;
          else                    cnt_d = LWH;
        end
      end
      WH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          state_d = WP;
          idx_d   = idx_q + 4'd1;
          cnt_d   = LWP;
        end
      end
      HOLD: begin
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        else             state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs for the upcoming cycle, registered below.
  always_comb begin
    cle_d  = cle_q;
    ale_d  = ale_q;
    wen_d  = 1'b1;
    oe_d   = oe_q;
    dq_d   = dq_q;
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
    unique case (state_d)
      WP: begin
        wen_d      = 1'b0;
        oe_d       = 1'b1;
        cle_d      = nb_cmd;
        ale_d      = !nb_cmd;
        dq_d       = '0;
        dq_d[7:0]  = nb_byte;
      end
      WH, HOLD: wen_d = 1'b1;
      default: begin
        cle_d = 1'b0;
        ale_d = 1'b0;
        oe_d  = 1'b0;
        dq_d  = '0;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      wen_q   <= 1'b1;
      oe_q    <= 1'b0;
      dq_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cle_q   <= cle_d;
      ale_q   <= ale_d;
      wen_q   <= wen_d;
      oe_q    <= oe_d;
      dq_q    <= dq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Request fields captured on the accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd0_q <= '0;
      cmd1_q <= '0;
      addr_q <= '0;
      acnt_q <= '0;
      c1en_q <= 1'b0;
    end else if (cap) begin
      cmd0_q <= cmd0;
      cmd1_q <= cmd1;
      addr_q <= addr;
      acnt_q <= addr_cnt;
      c1en_q <= cmd1_en;
    end
  end

  assign cle    = cle_q;
  assign ale    = ale_q;
  assign we_n   = wen_q;
  assign dq_oe  = oe_q;
  assign dq_out = dq_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_nand_latch_seq.sv
// Directed bench for nand_latch_seq.
// Default instance plus a fast-timing 8-bit instance.
module tb_nand_latch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, c1en;
  logic [7:0]  cmd0, cmd1;
  logic [39:0] addr;
  logic [3:0]  acnt;
  logic        cle, ale, we_n, dq_oe, busy, done, err;
  logic [15:0] dq_out;

  logic        start2, c1en2;
  logic [7:0]  cmd02, cmd12;
  logic [39:0] addr2;
  logic [3:0]  acnt2;
  logic        cle2, ale2, we_n2, dq_oe2, busy2, done2, err2;
  logic [7:0]  dq_out2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nand_latch_seq dut (
    .clk(clk), .rst(rst), .start(start), .cmd0(cmd0), .addr(addr),
    .addr_cnt(acnt), .cmd1_en(c1en), .cmd1(cmd1), .cle(cle), .ale(ale),
    .we_n(we_n), .dq_out(dq_out), .dq_oe(dq_oe), .busy(busy),
    .done(done), .err(err)
  );

  nand_latch_seq #(
    .DATA_W(8), .T_WP(1), .T_WH(1), .T_CLH(4)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cmd0(cmd02), .addr(addr2),
    .addr_cnt(acnt2), .cmd1_en(c1en2), .cmd1(cmd12), .cle(cle2),
    .ale(ale2), .we_n(we_n2), .dq_out(dq_out2), .dq_oe(dq_oe2),
    .busy(busy2), .done(done2), .err(err2)
  );

  // {cle,ale,we_n,dq_oe,busy,done,err}
  localparam logic [6:0] F_WPC  = 7'b1001100;
  localparam logic [6:0] F_HC   = 7'b1011100;
  localparam logic [6:0] F_WPA  = 7'b0101100;
  localparam logic [6:0] F_HA   = 7'b0111100;
  localparam logic [6:0] F_DONE = 7'b0010110;
  localparam logic [6:0] F_IDLE = 7'b0010000;
  localparam logic [6:0] F_ERR  = 7'b0010001;

  logic [22:0] o1;
  logic [14:0] o2;
  assign o1 = {cle, ale, we_n, dq_oe, busy, done, err, dq_out};
  assign o2 = {cle2, ale2, we_n2, dq_oe2, busy2, done2, err2, dq_out2};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] c0, input logic [3:0] n,
                    input logic [39:0] a, input logic e,
                    input logic [7:0] c1);
    cmd0  = c0;
    acnt  = n;
    addr  = a;
    c1en  = e;
    cmd1  = c1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int          pulses, apulses, lowc, ovl, dcnt, dat;
  logic        pwe;
  logic [55:0] bytes;

  initial begin
    rst = 1'b1; start = 1'b0; cmd0 = '0; cmd1 = '0; addr = '0;
    acnt = '0; c1en = 1'b0;
    start2 = 1'b0; cmd02 = '0; cmd12 = '0; addr2 = '0;
    acnt2 = '0; c1en2 = 1'b0;
    #12;
    chk("reset", 64'(o1), 64'({F_IDLE, 16'h0000}));
    rst = 1'b0;
    step();

    // Single command 0xFF
    go(8'hFF, 4'd0, 40'h0, 1'b0, 8'h00);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 3)      chk($sformatf("single_c%0d", c), 64'(o1), 64'({F_WPC, 16'h00FF}));
      else if (c <= 5) chk($sformatf("single_c%0d", c), 64'(o1), 64'({F_HC, 16'h00FF}));
      else if (c == 6) chk("single_done", 64'(o1), 64'({F_DONE, 16'h0000}));
      else             chk("single_idle", 64'(o1), 64'({F_IDLE, 16'h0000}));
      step();
    end

    // Page read: 00 / 5 addr bytes / 30
    go(8'h00, 4'd5, 40'h02_01_00_00_00, 1'b1, 8'h30);
    pulses = 0; apulses = 0; lowc = 0; ovl = 0; dcnt = 0; dat = 0;
    pwe = 1'b1; bytes = '0;
    for (int c = 1; c <= 40; c++) begin
      if (!we_n && pwe) begin
        pulses++;
        if (ale) apulses++;
        bytes = {bytes[47:0], dq_out[7:0]};
      end
      if (!we_n) lowc++;
      if (cle && ale) ovl++;
      if (done) begin dcnt++; dat = c; end
      pwe = we_n;
      step();
    end
    chk("pr_pulses", 64'(pulses), 64'd7);
    chk("pr_ale_pulses", 64'(apulses), 64'd5);
    chk("pr_we_low", 64'(lowc), 64'd21);
    chk("pr_overlap", 64'(ovl), 64'd0);
    chk("pr_done_cnt", 64'(dcnt), 64'd1);
    chk("pr_done_at", 64'(dat), 64'd36);
    chk("pr_bytes", 64'(bytes), 64'h00_00_00_00_00_01_02_30);

    // addr_cnt beyond MAX_ADDR
    go(8'h00, 4'd6, 40'h0, 1'b0, 8'h00);
    chk("err_c1", 64'(o1), 64'({F_ERR, 16'h0000}));
    step();
    chk("err_c2", 64'(o1), 64'({F_IDLE, 16'h0000}));
    step();

    // Re-pulsed start while busy
    go(8'hFF, 4'd0, 40'h0, 1'b0, 8'h00);
    step();
    step();
    cmd0  = 8'h55;
    start = 1'b1;
    step();
    start = 1'b0;
    dcnt = 0; dat = 0; ovl = 0;
    for (int c = 4; c <= 12; c++) begin
      if (c == 4) chk("rep_c4", 64'(o1), 64'({F_HC, 16'h00FF}));
      if (err) ovl++;
      if (done) begin dcnt++; dat = c; end
      step();
    end
    chk("rep_done_cnt", 64'(dcnt), 64'd1);
    chk("rep_done_at", 64'(dat), 64'd6);
    chk("rep_no_err", 64'(ovl), 64'd0);

    // Reset mid-WP of an address byte
    go(8'h00, 4'd5, 40'h02_01_00_00_00, 1'b1, 8'h30);
    for (int c = 1; c < 7; c++) step();
    chk("pre_rst", 64'({ale, we_n, dq_oe, busy}), 64'(4'b1011));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst", 64'({ale, we_n, dq_oe, busy}), 64'(4'b0100));
    #1;
    rst = 1'b0;
    step();
    go(8'hFF, 4'd0, 40'h0, 1'b0, 8'h00);
    chk("post_rst_c1", 64'(o1), 64'({F_WPC, 16'h00FF}));
    for (int c = 1; c < 6; c++) step();
    chk("post_rst_done", 64'(o1), 64'({F_DONE, 16'h0000}));
    step();
    step();

    // Fast 8-bit instance: 0x70 + one address byte
    cmd02 = 8'h70; acnt2 = 4'd1; addr2 = 40'h00_00_00_00_12;
    c1en2 = 1'b0; start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1)      chk("f8_c1", 64'(o2), 64'({F_WPC, 8'h70}));
      else if (c <= 5) chk($sformatf("f8_c%0d", c), 64'(o2), 64'({F_HC, 8'h70}));
      else if (c == 6) chk("f8_c6", 64'(o2), 64'({F_WPA, 8'h12}));
      else if (c <= 8) chk($sformatf("f8_c%0d", c), 64'(o2), 64'({F_HA, 8'h12}));
      else if (c == 9) chk("f8_done", 64'(o2), 64'({F_DONE, 8'h00}));
      else             chk("f8_idle", 64'(o2), 64'({F_IDLE, 8'h00}));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
